// File: rtl/multicycle_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_serial_adder_ctrl
//
// Bit-serial adder with a small control FSM. One start request captures two
// WIDTH-bit operands and a carry-in. The operands are then added LSB first,
// one bit per clock, through a single 1-bit full-adder cell. The cell is fed
// from two operand shift registers and a carry flip-flop. After WIDTH
// run cycles the assembled result and the final carry are copied to the
// output registers. At the same time a one-cycle done pulse is raised.
//
// Ports
//   clk    in   1      single clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      begin an addition (accepted only while busy is low)
//   a      in   WIDTH  operand A, captured on acceptance
//   b      in   WIDTH  operand B, captured on acceptance
//   cin    in   1      carry-in, captured on acceptance
//   busy   out  1      high while the addition is running
//   done   out  1      one-cycle pulse: sum/cout hold a fresh result
//   sum    out  WIDTH  (a + b + cin) mod 2^WIDTH of the last completed op
//   cout   out  1      carry out of bit WIDTH-1 of the last completed op
// -----------------------------------------------------------------------------
module multicycle_serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter wide enough to hold 0..WIDTH.
    localparam int CW = $clog2(WIDTH + 1);
    // The counter value seen on the WIDTH-th run edge.
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] res_sr_reg;
    logic             carry_reg;
    logic [CW-1:0]    count_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    // The single full-adder cell, working on the current LSBs.
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] res_next;

    assign fa_sum   = a_sr_reg[0] ^ b_sr_reg[0] ^ carry_reg;
    assign fa_carry = (a_sr_reg[0] & b_sr_reg[0]) |
                      (a_sr_reg[0] & carry_reg)   |
                      (b_sr_reg[0] & carry_reg);

    // Result bits enter at the MSB and move right. After WIDTH shifts the
    // first (LSB) result bit has reached position 0.
    assign res_next = {fa_sum, res_sr_reg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            res_sr_reg <= '0;
            carry_reg  <= 1'b0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
        end else begin
            case (state_reg)
                // IDLE and DONE both accept a new request. From DONE this
                // gives back-to-back operation with no idle gap. The done
                // pulse drops on every exit from DONE.
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_sr_reg  <= a;
                        b_sr_reg  <= b;
                        carry_reg <= cin;
                        count_reg <= '0;
                        state_reg <= RUN;
                        busy_reg  <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end

                // start is deliberately not looked at here. sum/cout stay
                // frozen until the last bit is produced.
                RUN: begin
                    res_sr_reg <= res_next;
                    carry_reg  <= fa_carry;
                    a_sr_reg   <= {1'b0, a_sr_reg[WIDTH-1:1]};
                    b_sr_reg   <= {1'b0, b_sr_reg[WIDTH-1:1]};
                    count_reg  <= count_reg + CW'(1);
                    if (count_reg == LAST_COUNT) begin
                        sum_reg   <= res_next;
                        cout_reg  <= fa_carry;
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    // busy/done are flops updated together with state_reg, so they always
    // equal (state==RUN) and (state==DONE) and cannot glitch.
    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule
